// File: rtl/issue_queue.sv
// Out-of-order issue queue: operands wake up from CDB broadcasts and the oldest
// ready entry is moved into a registered dispatch slot.

module iq_wake #(
    parameter int TAG_W = 4,
    parameter int N_CDB = 3
) (
    input  logic                   r,
    input  logic [TAG_W-1:0]       q,
    input  logic [31:0]            v,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*TAG_W-1:0] cdb_tag,
    input  logic [N_CDB*32-1:0]    cdb_data,
    output logic                   r_nxt,
    output logic [31:0]            v_nxt
);
    // Walk ports high to low so the lowest-index match is the last write.
    always_comb begin
        r_nxt = r;
        v_nxt = v;
        if (!r) begin
            for (int p = N_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == q) begin
                    r_nxt = 1'b1;
                    v_nxt = cdb_data[p*32 +: 32];
                end
            end
        end
    end
endmodule

module issue_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int N_CDB = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [OP_W-1:0]          issue_op,
    input  logic [31:0]              issue_vj,
    input  logic [31:0]              issue_vk,
    input  logic                     issue_rj,
    input  logic                     issue_rk,
    input  logic [TAG_W-1:0]         issue_qj,
    input  logic [TAG_W-1:0]         issue_qk,
    input  logic [31:0]              issue_imm,
    input  logic [31:0]              issue_pc,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic [N_CDB-1:0]         cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [N_CDB*32-1:0]      cdb_data,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [OP_W-1:0]          disp_op,
    output logic [31:0]              disp_vj,
    output logic [31:0]              disp_vk,
    output logic [31:0]              disp_imm,
    output logic [31:0]              disp_pc,
    output logic [TAG_W-1:0]         disp_tag,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // age = number of older busy entries, so the oldest entry has age 0
    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             rj;
        logic             rk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
        logic [IW-1:0]    age;
    } ent_t;

    ent_t [DEPTH-1:0]        ent;
    logic [DEPTH-1:0]        wj_r, wk_r;
    logic [DEPTH-1:0][31:0]  wj_v, wk_v;
    logic                    iss_rj, iss_rk;
    logic [31:0]             iss_vj, iss_vk;
    logic [IW-1:0]           free_idx, sel_idx, sel_age;
    logic                    any_elig, load, take, accept;
    ent_t                    new_ent;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        iq_wake #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_wj (
            .r(ent[g].rj), .q(ent[g].qj), .v(ent[g].vj),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
            .r_nxt(wj_r[g]), .v_nxt(wj_v[g]));
        iq_wake #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_wk (
            .r(ent[g].rk), .q(ent[g].qk), .v(ent[g].vk),
            .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
            .r_nxt(wk_r[g]), .v_nxt(wk_v[g]));
    end

    // Same-cycle bypass for operands arriving with the broadcast they wait on
    iq_wake #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_iss_j (
        .r(issue_rj), .q(issue_qj), .v(issue_vj),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .r_nxt(iss_rj), .v_nxt(iss_vj));
    iq_wake #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_iss_k (
        .r(issue_rk), .q(issue_qk), .v(issue_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .r_nxt(iss_rk), .v_nxt(iss_vk));

    assign issue_ready = (count < CW'(DEPTH));
    assign accept      = issue_valid & issue_ready;
    assign load        = ~disp_valid | disp_ready;
    assign take        = load & any_elig;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!ent[i].busy) free_idx = IW'(i);
    end

    always_comb begin
        any_elig = 1'b0;
        sel_idx  = '0;
        sel_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].busy && ent[i].rj && ent[i].rk &&
                (!any_elig || ent[i].age < sel_age)) begin
                any_elig = 1'b1;
                sel_idx  = IW'(i);
                sel_age  = ent[i].age;
            end
        end
    end

    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = issue_op;
        new_ent.vj   = iss_vj;
        new_ent.vk   = iss_vk;
        new_ent.rj   = iss_rj;
        new_ent.rk   = iss_rk;
        new_ent.qj   = issue_qj;
        new_ent.qk   = issue_qk;
        new_ent.imm  = issue_imm;
        new_ent.pc   = issue_pc;
        new_ent.tag  = issue_tag;
        new_ent.age  = IW'(count - CW'(take));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].busy <= 1'b0;
                ent[i].rj   <= 1'b0;
                ent[i].rk   <= 1'b0;
            end
            count      <= '0;
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_vj    <= '0;
            disp_vk    <= '0;
            disp_imm   <= '0;
            disp_pc    <= '0;
            disp_tag   <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
                count      <= '0;
                disp_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent[i].busy) begin
                        ent[i].rj <= wj_r[i];
                        ent[i].vj <= wj_v[i];
                        ent[i].rk <= wk_r[i];
                        ent[i].vk <= wk_v[i];
                        if (take && ent[i].age > sel_age)
                            ent[i].age <= ent[i].age - IW'(1);
                    end
                end
                if (take) ent[sel_idx].busy <= 1'b0;
                if (accept) ent[free_idx] <= new_ent;
                count <= count + CW'(accept) - CW'(take);
                if (load) begin
                    disp_valid <= any_elig;
                    if (any_elig) begin
                        disp_op  <= ent[sel_idx].op;
                        disp_vj  <= ent[sel_idx].vj;
                        disp_vk  <= ent[sel_idx].vk;
                        disp_imm <= ent[sel_idx].imm;
                        disp_pc  <= ent[sel_idx].pc;
                        disp_tag <= ent[sel_idx].tag;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed bench for issue_queue with an in-order-list reference
// model and a dispatch scoreboard popped by an independent monitor.

module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam int N_CDB = 3;

    logic                   clk = 1'b0;
    logic                   rst, rdy, flush;
    logic                   issue_valid, issue_ready;
    logic [OP_W-1:0]        issue_op;
    logic [31:0]            issue_vj, issue_vk, issue_imm, issue_pc;
    logic                   issue_rj, issue_rk;
    logic [TAG_W-1:0]       issue_qj, issue_qk, issue_tag;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB*32-1:0]    cdb_data;
    logic                   disp_valid, disp_ready;
    logic [OP_W-1:0]        disp_op;
    logic [31:0]            disp_vj, disp_vk, disp_imm, disp_pc;
    logic [TAG_W-1:0]       disp_tag;
    logic [$clog2(DEPTH):0] count;

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .N_CDB(N_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_rj(issue_rj), .issue_rk(issue_rk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_tag(disp_tag), .count(count));

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [31:0]      vj, vk, imm, pc;
        logic             rj, rk;
        logic [TAG_W-1:0] qj, qk, tag;
    } m_ent_t;

    m_ent_t mq[$];     // waiting instructions, oldest first
    m_ent_t exp_q[$];  // instruction expected in the dispatch register
    bit     m_dv;
    int     checks = 0;
    int     failures = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic m_ent_t wake(input m_ent_t e);
        for (int p = 0; p < N_CDB; p++) begin
            if (cdb_valid[p]) begin
                if (!e.rj && cdb_tag[p*TAG_W +: TAG_W] == e.qj) begin
                    e.rj = 1'b1; e.vj = cdb_data[p*32 +: 32];
                end
                if (!e.rk && cdb_tag[p*TAG_W +: TAG_W] == e.qk) begin
                    e.rk = 1'b1; e.vk = cdb_data[p*32 +: 32];
                end
            end
        end
        return e;
    endfunction

    // Reference behaviour for one rising edge, from the inputs present at it
    task automatic model_edge();
        bit acc;
        int k;
        m_ent_t e;
        if (rst) begin
            mq.delete(); exp_q.delete(); m_dv = 0;
        end else if (rdy) begin
            if (flush) begin
                mq.delete(); exp_q.delete(); m_dv = 0;
            end else begin
                acc = issue_valid && (mq.size() < DEPTH);
                if (!m_dv || disp_ready) begin
                    k = -1;
                    foreach (mq[i]) if (k < 0 && mq[i].rj && mq[i].rk) k = i;
                    if (k >= 0) begin
                        exp_q.push_back(mq[k]); mq.delete(k); m_dv = 1;
                    end else m_dv = 0;
                end
                foreach (mq[i]) mq[i] = wake(mq[i]);
                if (acc) begin
                    e = '{op: issue_op, vj: issue_vj, vk: issue_vk, imm: issue_imm,
                          pc: issue_pc, rj: issue_rj, rk: issue_rk, qj: issue_qj,
                          qk: issue_qk, tag: issue_tag};
                    mq.push_back(wake(e));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; cdb_valid = '0; flush = 0;
    endtask

    task automatic set_iss(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic rj, input logic rk, input logic [TAG_W-1:0] qj,
                           input logic [TAG_W-1:0] qk, input logic [TAG_W-1:0] tag);
        issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
        issue_rj = rj; issue_rk = rk; issue_qj = qj; issue_qk = qk; issue_tag = tag;
        issue_imm = $urandom; issue_pc = $urandom;
    endtask

    // Monitor: state compare, hold stability, and scoreboard pop on handshake
    initial begin
        bit                   prev_hold = 0;
        logic [137:0]         prev_pay = '0;
        logic [137:0]         pay;
        m_ent_t               e;
        forever begin
            @(negedge clk);
            pay = {disp_op, disp_vj, disp_vk, disp_imm, disp_pc, disp_tag};
            if (!rst) begin
                chk("count", 160'(count), 160'(mq.size()));
                chk("issue_ready", 160'(issue_ready), 160'(mq.size() < DEPTH));
                chk("disp_valid", 160'(disp_valid), 160'(m_dv));
                if (prev_hold) chk("disp_hold", 160'(pay), 160'(prev_pay));
                if (rdy && !flush && disp_valid && disp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_empty actual=dispatch required=none tag=%0h", disp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("disp_payload", 160'(pay),
                            160'({e.op, e.vj, e.vk, e.imm, e.pc, e.tag}));
                    end
                end
            end
            prev_hold = !rst && !flush && disp_valid && !(rdy && disp_ready);
            prev_pay  = pay;
        end
    end

    initial begin
        rst = 1; rdy = 1; flush = 0; disp_ready = 1;
        issue_valid = 0; issue_op = '0; issue_vj = '0; issue_vk = '0; issue_rj = 0; issue_rk = 0;
        issue_qj = '0; issue_qk = '0; issue_imm = '0; issue_pc = '0; issue_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        step(); step();
        chk("rst_count", 160'(count), 160'(0));
        chk("rst_issue_ready", 160'(issue_ready), 160'(1));
        chk("rst_disp_valid", 160'(disp_valid), 160'(0));
        rst = 0; step();

        // single ready instruction: two-edge latency
        set_iss(6'h01, 32'd5, 32'd7, 1, 1, 4'd0, 4'd0, 4'd3); step();
        chk("lat_count1", 160'(count), 160'(1));
        chk("lat_dv0", 160'(disp_valid), 160'(0));
        idle(); step();
        chk("lat_dv1", 160'(disp_valid), 160'(1));
        chk("lat_vj", 160'(disp_vj), 160'(5));
        chk("lat_vk", 160'(disp_vk), 160'(7));
        chk("lat_tag", 160'(disp_tag), 160'(3));
        chk("lat_count0", 160'(count), 160'(0));
        step();

        // waiting A overtaken by ready B, then A woken on port 1
        set_iss(6'h02, 32'h0, 32'h1, 0, 1, 4'd2, 4'd0, 4'd8); step();
        set_iss(6'h03, 32'h9, 32'h9, 1, 1, 4'd0, 4'd0, 4'd9); step();
        idle(); cdb_valid = 3'b010; cdb_tag = {4'd0, 4'd2, 4'd0};
        cdb_data = {32'h0, 32'h10, 32'h0}; step();
        idle(); repeat (4) step();

        // fill with waiting entries, then wake all in one cycle
        for (int i = 0; i < DEPTH; i++) begin
            set_iss(OP_W'(i), 32'h0, 32'(i), 0, 1, TAG_W'(1 + i % 3), 4'd0, TAG_W'(i)); step();
        end
        idle();
        chk("full_issue_ready", 160'(issue_ready), 160'(0));
        chk("full_count", 160'(count), 160'(DEPTH));
        cdb_valid = 3'b111; cdb_tag = {4'd3, 4'd2, 4'd1};
        cdb_data = {32'hCCCC, 32'hBBBB, 32'hAAAA}; step();
        idle(); repeat (12) step();
        chk("drain_count", 160'(count), 160'(0));

        // back-pressure
        disp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_iss(6'h10, 32'(i), 32'(i), 1, 1, 4'd0, 4'd0, TAG_W'(4 + i)); step();
        end
        idle(); repeat (3) step();
        chk("bp_count", 160'(count), 160'(2));
        disp_ready = 1; repeat (4) step();
        chk("bp_drain", 160'(count), 160'(0));

        // issue bypass from port 0
        set_iss(6'h05, 32'h1, 32'h0, 1, 0, 4'd0, 4'd6, 4'hC);
        cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd6}; cdb_data = {32'h0, 32'h0, 32'hAB};
        step(); idle(); step();
        chk("byp_dv", 160'(disp_valid), 160'(1));
        chk("byp_vk", 160'(disp_vk), 160'(32'hAB));
        step();

        // rdy low freezes everything, then flush with a pending dispatch
        disp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_iss(6'h20, 32'(i), 32'(i), 1, 1, 4'd0, 4'd0, TAG_W'(i)); step();
        end
        rdy = 0; disp_ready = 1; cdb_valid = 3'b111; cdb_tag = $urandom; cdb_data = {3{$urandom}};
        step(); step();
        chk("frz_count", 160'(count), 160'(3));
        chk("frz_dv", 160'(disp_valid), 160'(1));
        rdy = 1; disp_ready = 0; idle();
        for (int i = 0; i < 2; i++) begin
            set_iss(6'h21, 32'(i), 32'(i), 1, 1, 4'd0, 4'd0, TAG_W'(i)); step();
        end
        chk("pre_flush_count", 160'(count), 160'(5));
        flush = 1; issue_valid = 1; cdb_valid = 3'b001; step();
        idle();
        chk("flush_count", 160'(count), 160'(0));
        chk("flush_dv", 160'(disp_valid), 160'(0));

        // reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            set_iss(6'h22, 32'(i), 32'(i), 1, 1, 4'd0, 4'd0, TAG_W'(i)); step();
        end
        idle(); rst = 1; step(); rst = 0;
        chk("mid_rst_count", 160'(count), 160'(0));
        chk("mid_rst_dv", 160'(disp_valid), 160'(0));
        chk("mid_rst_ready", 160'(issue_ready), 160'(1));

        // random traffic
        repeat (3000) begin
            rst   = ($urandom_range(0, 299) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            disp_ready = ($urandom_range(0, 9) < 7);
            issue_valid = $urandom_range(0, 1);
            issue_op = OP_W'($urandom); issue_vj = $urandom; issue_vk = $urandom;
            issue_rj = $urandom_range(0, 1); issue_rk = $urandom_range(0, 1);
            issue_qj = TAG_W'($urandom_range(0, 7)); issue_qk = TAG_W'($urandom_range(0, 7));
            issue_imm = $urandom; issue_pc = $urandom; issue_tag = TAG_W'($urandom);
            for (int p = 0; p < N_CDB; p++) begin
                cdb_valid[p] = ($urandom_range(0, 3) == 0);
                cdb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
                cdb_data[p*32 +: 32] = $urandom;
            end
            step();
        end
        rst = 0; rdy = 1; idle(); disp_ready = 1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries (power of two, 2..32).
REQ-002 Parameter TAG_W, default 4, ROB tag width.
REQ-003 Parameter OP_W, default 6, opcode width.
REQ-004 Parameter N_CDB, default 3, number of result broadcast (wake-up) ports.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global enable; low freezes all state and outputs.
REQ-008 flush  in  1  misprediction rollback; discards all entries.
REQ-009 issue_valid  in  1  issue request.
REQ-010 issue_ready  out  1  entry free; issue accepted when issue_valid & issue_ready.
REQ-011 issue_op  in  OP_W  opcode.
REQ-012 issue_vj, issue_vk  in  32 each  operand values (valid when matching R bit set).
REQ-013 issue_rj, issue_rk  in  1 each  operand ready flags.
REQ-014 issue_qj, issue_qk  in  TAG_W each  producer tags for not-ready operands.
REQ-015 issue_imm, issue_pc  in  32 each  immediate, instruction PC.
REQ-016 issue_tag  in  TAG_W  destination ROB tag.
REQ-017 cdb_valid  in  N_CDB  per-port broadcast valid.
REQ-018 cdb_tag  in  N_CDB*TAG_W  packed tags, port p at bits [p*TAG_W +: TAG_W].
REQ-019 cdb_data  in  N_CDB*32  packed results, port p at bits [p*32 +: 32].
REQ-020 disp_valid  out  1  registered dispatch valid to execution unit.
REQ-021 disp_ready  in  1  execution unit accepts dispatch.
REQ-022 disp_op, disp_vj, disp_vk, disp_imm, disp_pc, disp_tag  out  OP_W/32/32/32/32/TAG_W  registered dispatch payload.
REQ-023 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-024 Each entry SHALL hold busy, op, Vj, Vk, Rj, Rk, Qj, Qk, imm, pc, tag and an issue-order age.
REQ-025 issue_ready SHALL equal (count < DEPTH), derived from registered state only; a slot freed this cycle is not reusable until next cycle.
REQ-026 Accepted issue SHALL write the lowest-index free entry at the edge.
REQ-027 Wake-up: for every busy entry with Rj=0 and any cdb_valid[p] with cdb_tag[p]==Qj, Vj<=cdb_data[p], Rj<=1; identically for k; lowest-index matching port wins.
REQ-028 Issue bypass: an issuing operand with R=0 whose Q matches a valid CDB port in the same cycle SHALL be written ready with that port's data.
REQ-029 An entry SHALL be eligible for selection when busy & Rj & Rk using registered flags (no same-cycle wake-up-to-select).
REQ-030 Output register is loadable when disp_valid==0 or disp_ready==1; if loadable and any entry eligible, the OLDEST eligible entry (earliest accepted issue) SHALL be copied to disp_* , disp_valid<=1, entry busy<=0; if loadable and none eligible, disp_valid<=0.
REQ-031 While disp_valid==1 and disp_ready==0, disp_* SHALL hold stable and no entry is freed.
REQ-032 Latency: issue with both operands ready accepted at edge E -> disp_valid high after edge E+1 (queue otherwise empty, disp_ready=1); CDB wake-up at edge E -> disp_valid after E+1.
REQ-033 count SHALL update each edge by +1 for accepted issue, -1 for entry moved to output register, both allowed in one cycle.
REQ-034 Age ordering SHALL remain correct across arbitrary interleaving of issue and dispatch, including full-to-empty wrap of slot indices.
REQ-035 flush SHALL clear all busy bits, count<=0, disp_valid<=0 at the edge; same-cycle issue and wake-ups are discarded.
REQ-036 rdy==0 SHALL freeze all state; issue and CDB inputs in that cycle are ignored; disp_ready ignored.

Reset
REQ-037 rst SHALL have priority over flush and rdy; after reset: all busy=0, Rj=Rk=0, count=0, issue_ready=1, disp_valid=0; disp payload don't-care.
REQ-038 Reset asserted mid-operation SHALL discard all entries and any pending dispatch in one edge.

Verification
REQ-039 Issue op=ADD, rj=rk=1, vj=5, vk=7, tag=3 into empty queue, disp_ready=1 -> disp_valid next-next edge with vj=5, vk=7, tag=3; count 1 then 0.
REQ-040 Issue A (qj=2 unready) then B (ready); cdb port1 tag=2 data=0x10 -> B dispatches first, A dispatches later with vj=0x10.
REQ-041 Fill DEPTH entries, all unready -> issue_ready=0, count=DEPTH; broadcast all tags same cycle on different ports -> entries dispatch in issue order.
REQ-042 Hold disp_ready=0 three cycles with eligible entries -> disp_* stable, count unchanged; release -> one entry per cycle.
REQ-043 Issue with qk=6 unready while cdb port0 tag=6 data=0xAB same cycle -> entry stored ready, dispatched with vk=0xAB.
REQ-044 flush with 5 entries and disp_valid=1 -> next cycle count=0, disp_valid=0; rdy=0 for 2 cycles -> all outputs unchanged.
